// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction-fetch unit.
//   state_t     : two-state fetch FSM encoding (S_FETCH, S_VALID)
//   RESET_PC    : address of the first fetch after reset
//   INSTR_STEP  : byte distance between consecutive instructions
//   word_align  : clears the two low address bits of a byte address
// ----------------------------------------------------------------------------
package ifetch_pkg;

   typedef enum logic {
      S_FETCH = 1'b0,   // request outstanding, waiting for imem_ack
      S_VALID = 1'b1    // instruction presented, waiting for consume
   } state_t;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] INSTR_STEP = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_if.sv
// ----------------------------------------------------------------------------
// ifetch_if
// Instruction-memory read channel between the fetch unit and memory.
//   imem_req   : read request (held until imem_ack)
//   imem_addr  : word-aligned fetch address
//   imem_ack   : imem_rdata is valid this cycle
//   imem_rdata : instruction word
// Modports: master (fetch unit side), slave (memory side).
// ----------------------------------------------------------------------------
interface ifetch_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/ifetch_next_pc.sv
// ----------------------------------------------------------------------------
// ifetch_next_pc
// Combinational next-fetch-address selection.
//   consume     : presented instruction is accepted this cycle
//   pc_out      : address of the presented instruction
//   branch/jump/cond/target : redirect request from control
//   next_pc     : address to fetch after the presented instruction
//   err_set     : a taken redirect carried a misaligned target
// Optional feature (macro IFETCH_DELAY_SLOT_EN): a taken redirect fetches the
// delay slot first and parks the aligned target in a pending register owned by
// the caller; extra ports:
//   pend_valid  : the presented instruction is a delay slot
//   pend_target : parked redirect target
//   pend_load   : park pend_next now
//   pend_clear  : delay slot consumed, pending target is being fetched
//   pend_next   : aligned target to park
// ----------------------------------------------------------------------------
module ifetch_next_pc
   import ifetch_pkg::*;
(
   input  logic        consume,
   input  logic [31:0] pc_out,
   input  logic        branch,
   input  logic        jump,
   input  logic        cond,
   input  logic [31:0] target,
`ifdef IFETCH_DELAY_SLOT_EN
   input  logic        pend_valid,
   input  logic [31:0] pend_target,
   output logic        pend_load,
   output logic        pend_clear,
   output logic [31:0] pend_next,
`endif
   output logic [31:0] next_pc,
   output logic        err_set
);

   logic        redirect;
   logic        misaligned;
   logic [31:0] seq_pc;

   assign redirect   = jump | (branch & cond);
   assign misaligned = (target[1:0] != 2'b00);
   // Plain 32-bit add: 0xFFFFFFFC + 4 wraps to 0x00000000 by construction.
   assign seq_pc     = pc_out + INSTR_STEP;

`ifdef IFETCH_DELAY_SLOT_EN
   assign pend_next = word_align(target);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // (an unassigned path in always_comb would infer a latch).
      next_pc    = seq_pc;
      err_set    = 1'b0;
      pend_load  = 1'b0;
      pend_clear = 1'b0;
      if (pend_valid) begin
         // Delay slot: its own branch/jump fields are ignored.
         next_pc    = pend_target;
         pend_clear = consume;
      end else if (redirect) begin
         // Fetch the delay slot (sequential) and park the target.
         pend_load = consume;
         err_set   = consume & misaligned;
      end
   end
`else
   always_comb begin
      next_pc = seq_pc;
      err_set = 1'b0;
      if (redirect) begin
         next_pc = word_align(target);
         err_set = consume & misaligned;
      end
   end
`endif

endmodule

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Two-state instruction-fetch FSM. Issues one read at a time on the imem
// channel, presents the returned word to control and advances (or redirects)
// the fetch address when control consumes it.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   stall       : control cannot accept the presented instruction
//   branch/jump/cond/target : redirect request, sampled only on consume
//   imem        : ifetch_if.master instruction-memory channel
//   instruction : presented instruction word
//   pc_out      : address of the presented instruction
//   instr_valid : instruction/pc_out valid
//   addr_err    : sticky, a misaligned redirect target was received
// Build option: define IFETCH_DELAY_SLOT_EN for single-delay-slot redirects.
// ----------------------------------------------------------------------------
module ifetch_unit
   import ifetch_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch,
   input  logic             jump,
   input  logic             cond,
   input  logic [31:0]      target,
   ifetch_if.master         imem,
   output logic [31:0]      instruction,
   output logic [31:0]      pc_out,
   output logic             instr_valid,
   output logic             addr_err
);

   state_t      state;
   logic [31:0] pc;        // address of the outstanding / next fetch
   logic [31:0] next_pc;
   logic        err_set;
   logic        consume;

`ifdef IFETCH_DELAY_SLOT_EN
   logic        pend_valid;
   logic [31:0] pend_target;
   logic        pend_load;
   logic        pend_clear;
   logic [31:0] pend_next;
`endif

   assign consume = (state == S_VALID) && !stall;

   ifetch_next_pc u_next_pc (
      .consume     (consume),
      .pc_out      (pc_out),
      .branch      (branch),
      .jump        (jump),
      .cond        (cond),
      .target      (target),
`ifdef IFETCH_DELAY_SLOT_EN
      .pend_valid  (pend_valid),
      .pend_target (pend_target),
      .pend_load   (pend_load),
      .pend_clear  (pend_clear),
      .pend_next   (pend_next),
`endif
      .next_pc     (next_pc),
      .err_set     (err_set)
   );

   // Request is a decode of the state register. Gating with reset keeps it
   // low while reset is held and lets it rise in the very first cycle after
   // release, when the state register already sits in S_FETCH.
   assign imem.imem_req  = (state == S_FETCH) && !reset;
   assign imem.imem_addr = pc;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_FETCH;
         pc          <= RESET_PC;
         instruction <= 32'h0000_0000;
         pc_out      <= RESET_PC;
         instr_valid <= 1'b0;
         addr_err    <= 1'b0;
`ifdef IFETCH_DELAY_SLOT_EN
         pend_valid  <= 1'b0;
         pend_target <= RESET_PC;
`endif
      end else begin
         if (err_set) begin
            addr_err <= 1'b1;
         end
         case (state)
            S_FETCH: begin
               // pc is not touched here, so the request address stays
               // constant until the ack arrives.
               if (imem.imem_ack) begin
                  instruction <= imem.imem_rdata;
                  pc_out      <= pc;
                  instr_valid <= 1'b1;
                  state       <= S_VALID;
               end
            end
            S_VALID: begin
               if (!stall) begin
                  pc          <= next_pc;
                  instr_valid <= 1'b0;
                  state       <= S_FETCH;
`ifdef IFETCH_DELAY_SLOT_EN
                  if (pend_load) begin
                     pend_valid  <= 1'b1;
                     pend_target <= pend_next;
                  end else if (pend_clear) begin
                     pend_valid  <= 1'b0;
                  end
`endif
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
// Directed self-checking bench for ifetch_unit. The bench plays the memory
// side of ifetch_if and the control side. Inputs are driven and outputs are
// sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall  = 1'b0;
   logic        branch = 1'b0;
   logic        jump   = 1'b0;
   logic        cond   = 1'b0;
   logic [31:0] target = 32'h0;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        addr_err;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc = 32'h0;

   always #5 clk = ~clk;

   ifetch_if imem ();

   ifetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .branch      (branch),
      .jump        (jump),
      .cond        (cond),
      .target      (target),
      .imem        (imem),
      .instruction (instruction),
      .pc_out      (pc_out),
      .instr_valid (instr_valid),
      .addr_err    (addr_err)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Wait (bounded) for a request.
   task automatic wait_req();
      int n = 0;
      while (imem.imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (imem.imem_req !== 1'b1) begin
         errors++;
         $display("FAIL req_timeout: imem_req=%b required 1", imem.imem_req);
      end
   endtask

   // Serve one fetch with a same-cycle ack and check the presented result.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
      wait_req();
      checks++;
      if (imem.imem_addr !== addr) begin
         errors++;
         $display("FAIL fetch_addr: got %h required %h", imem.imem_addr, addr);
      end
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = data;
      @(negedge clk);
      imem.imem_ack   = 1'b0;
      checks++;
      if (instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL fetch_valid: got %b required 1", instr_valid);
      end
      checks++;
      if (instruction !== data) begin
         errors++;
         $display("FAIL fetch_instr: got %h required %h", instruction, data);
      end
      checks++;
      if (pc_out !== addr) begin
         errors++;
         $display("FAIL fetch_pc_out: got %h required %h", pc_out, addr);
      end
      checks++;
      if (imem.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL valid_req: got %b required 0", imem.imem_req);
      end
      exp_pc = addr;
   endtask

   // Consume the presented instruction with the given redirect inputs.
   task automatic do_consume(input logic br, input logic jp, input logic cd,
                             input logic [31:0] tgt);
      stall  = 1'b0;
      branch = br;
      jump   = jp;
      cond   = cd;
      target = tgt;
      @(negedge clk);
      branch = 1'b0;
      jump   = 1'b0;
      cond   = 1'b0;
      target = 32'h0;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL consume_valid: got %b required 0", instr_valid);
      end
   endtask

   // Jump to tgt; with delay slots, fetch and retire the slot first.
   task automatic redirect_to(input logic [31:0] tgt);
      do_consume(1'b0, 1'b1, 1'b0, tgt);
`ifdef IFETCH_DELAY_SLOT_EN
      do_fetch(exp_pc + 32'd4, 32'h0000_0000);
      do_consume(1'b0, 1'b0, 1'b0, 32'h0);
`endif
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      imem.imem_ack   = 1'b1;     // ack while in reset must be discarded
      imem.imem_rdata = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      checks++;
      if (imem.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_req: got %b required 0", imem.imem_req);
      end
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b required 0", instr_valid);
      end
      checks++;
      if (instruction !== 32'h0) begin
         errors++;
         $display("FAIL reset_instr: got %h required 00000000", instruction);
      end
      checks++;
      if (pc_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_pc_out: got %h required 00000000", pc_out);
      end
      checks++;
      if (addr_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_addr_err: got %b required 0", addr_err);
      end
   endtask

   task automatic test_first_fetch();
      imem.imem_rdata = 32'h0062_0824;
      reset = 1'b0;               // ack already high in the release cycle
      #1;
      checks++;
      if (imem.imem_req !== 1'b1) begin
         errors++;
         $display("FAIL first_req: got %b required 1", imem.imem_req);
      end
      checks++;
      if (imem.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL first_addr: got %h required 00000000", imem.imem_addr);
      end
      @(negedge clk);
      imem.imem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_valid: got %b required 1", instr_valid);
      end
      checks++;
      if (instruction !== 32'h0062_0824) begin
         errors++;
         $display("FAIL first_instr: got %h required 00620824", instruction);
      end
      checks++;
      if (pc_out !== 32'h0) begin
         errors++;
         $display("FAIL first_pc_out: got %h required 00000000", pc_out);
      end
      exp_pc = 32'h0;
   endtask

   task automatic test_stall();
      // Redirect inputs asserted during stall must have no effect.
      stall  = 1'b1;
      jump   = 1'b1;
      branch = 1'b1;
      cond   = 1'b1;
      target = 32'h0000_0300;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (instruction !== 32'h0062_0824 || pc_out !== 32'h0 ||
             instr_valid !== 1'b1 || imem.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: instr=%h pc_out=%h valid=%b req=%b required 00620824 00000000 1 0",
                     i, instruction, pc_out, instr_valid, imem.imem_req);
         end
      end
      do_consume(1'b0, 1'b0, 1'b0, 32'h0);
      do_fetch(32'h0000_0004, 32'h1111_1111);
   endtask

   task automatic test_jump();
      redirect_to(32'h0000_0010);
      do_fetch(32'h0000_0010, 32'h0800_0040);
      do_consume(1'b0, 1'b1, 1'b0, 32'h0000_0100);
`ifdef IFETCH_DELAY_SLOT_EN
      do_fetch(32'h0000_0014, 32'h2222_2222);
      do_consume(1'b1, 1'b1, 1'b1, 32'h0000_0200);  // ignored in delay slot
`endif
      do_fetch(32'h0000_0100, 32'h3333_3333);
   endtask

   task automatic test_branch();
      redirect_to(32'h0000_0020);
      do_fetch(32'h0000_0020, 32'h1400_0008);
      checks++;
      if (addr_err !== 1'b0) begin
         errors++;
         $display("FAIL err_before: got %b required 0", addr_err);
      end
      do_consume(1'b1, 1'b0, 1'b0, 32'h0000_0080);  // not taken
      do_fetch(32'h0000_0024, 32'h1400_0010);
      do_consume(1'b1, 1'b0, 1'b1, 32'h0000_0042);  // taken, misaligned
      checks++;
      if (addr_err !== 1'b1) begin
         errors++;
         $display("FAIL err_set: got %b required 1", addr_err);
      end
`ifdef IFETCH_DELAY_SLOT_EN
      do_fetch(32'h0000_0028, 32'h0000_0000);
      do_consume(1'b0, 1'b0, 1'b0, 32'h0);
`endif
      do_fetch(32'h0000_0040, 32'h4444_4444);
   endtask

   task automatic test_wrap();
      redirect_to(32'hFFFF_FFFC);
      do_fetch(32'hFFFF_FFFC, 32'h5555_5555);
      do_consume(1'b0, 1'b0, 1'b0, 32'h0);
      do_fetch(32'h0000_0000, 32'h6666_6666);
      checks++;
      if (addr_err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %b required 1", addr_err);
      end
   endtask

   task automatic test_reset_mid_fetch();
      do_consume(1'b0, 1'b0, 1'b0, 32'h0);  // now requesting 0x4
      wait_req();
      reset = 1'b1;
      #1;
      checks++;
      if (imem.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL midrst_req: got %b required 0", imem.imem_req);
      end
      @(negedge clk);
      imem.imem_ack   = 1'b1;             // late ack, arrives during reset
      imem.imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      imem.imem_ack = 1'b0;
      reset         = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_valid: got %b required 0", instr_valid);
      end
      checks++;
      if (addr_err !== 1'b0) begin
         errors++;
         $display("FAIL midrst_err: got %b required 0", addr_err);
      end
      checks++;
      if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL midrst_fetch: req=%b addr=%h required 1 00000000",
                  imem.imem_req, imem.imem_addr);
      end
      do_fetch(32'h0000_0000, 32'h7777_7777);
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_stall();
      test_jump();
      test_branch();
      test_wrap();
      test_reset_mid_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 stall  input  1  decode/control stage cannot accept the presented instruction this cycle.
REQ-004 branch  input  1  decoded instruction is a conditional branch (from control).
REQ-005 jump  input  1  decoded instruction is an unconditional jump (from control).
REQ-006 cond  input  1  branch condition true (bnez/beqz test result).
REQ-007 target  input  32  absolute byte target address for branch/jump.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  32  word-aligned fetch address.
REQ-010 imem_ack  input  1  read data valid on imem_rdata this cycle.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instruction  output  32  instruction presented to control.
REQ-013 pc_out  output  32  address of the presented instruction.
REQ-014 instr_valid  output  1  instruction/pc_out valid.
REQ-015 addr_err  output  1  sticky flag: a misaligned redirect target was received.

Function
REQ-016 The FSM SHALL have two states: FETCH (imem_req=1, imem_addr=pc) and VALID (imem_req=0, instr_valid=1).
REQ-017 In FETCH, on imem_ack=1 the block SHALL register imem_rdata into instruction, pc into pc_out, and enter VALID next cycle.
REQ-018 imem_req and imem_addr SHALL stay constant while in FETCH until ack; at most one request is outstanding.
REQ-019 Consume SHALL be defined as VALID && !stall; without consume, instruction, pc_out and instr_valid hold.
REQ-020 On consume the FSM SHALL return to FETCH with pc updated per REQ-021..023; minimum throughput is one instruction per 2 cycles (ack in the request cycle).
REQ-021 Redirect SHALL be taken when jump=1, or branch=1 && cond=1, sampled only in the consume cycle.
REQ-022 Next pc without redirect SHALL be pc_out+4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-023 Redirect target SHALL have bits [1:0] forced to 0; if target[1:0]!=0, addr_err SHALL set and hold until reset.
REQ-024 branch/jump/cond/target SHALL be ignored outside consume cycles.

Reset
REQ-025 Reset SHALL asynchronously force state=FETCH, pc=0x00000000, instruction=0x00000000, pc_out=0x00000000, instr_valid=0, addr_err=0, pending-redirect cleared.
REQ-026 imem_req SHALL be 0 while reset is asserted and SHALL assert in the first cycle after deassertion with imem_addr=0x00000000.
REQ-027 An ack arriving during reset SHALL be discarded.

Configuration
REQ-028 With IFETCH_DELAY_SLOT_EN defined, a taken redirect SHALL store target in a pending register, fetch pc_out+4 (delay slot) next, then fetch the pending target after the delay slot is consumed.
REQ-029 With IFETCH_DELAY_SLOT_EN defined, branch/jump in a delay-slot instruction SHALL be ignored.
REQ-030 Without IFETCH_DELAY_SLOT_EN, a taken redirect SHALL make the next fetch address the target directly; no pending register exists.

Structure
REQ-031 Package ifetch_pkg SHALL hold the state enum, RESET_PC (0x00000000), and the 4-byte instruction-step constant.
REQ-032 Next-pc selection (sequential/redirect/pending, alignment, error detect) SHALL be one combinational sub-module ifetch_next_pc; the FSM and registers stay in ifetch_unit.

Verification
REQ-033 Reset release, imem_ack=1 same cycle, rdata 0x00620824 -> imem_addr 0x0, instruction 0x00620824, pc_out 0x0, instr_valid=1 on cycle 2.
REQ-034 stall=1 for 3 cycles while VALID -> instruction/pc_out unchanged, imem_req=0; stall=0 -> next imem_addr 0x4.
REQ-035 Consume jump at pc_out 0x10, target 0x100, macro off -> next imem_addr 0x100; macro on -> 0x14, then 0x100.
REQ-036 branch=1, cond=0 at 0x20 -> next fetch 0x24; cond=1, target 0x42 -> fetch 0x40, addr_err=1 until reset.
REQ-037 Sequential fetch at 0xFFFFFFFC -> next imem_addr 0x00000000.
REQ-038 reset asserted mid-FETCH with ack 1 cycle later -> ack ignored, instr_valid=0, first post-reset imem_addr 0x0.
